// File: rtl/iso_tree_scorer.sv
// iso_tree_scorer: walks a programmable isolation tree one level per clock for
// each accepted sample and reports path length, anomaly flag and channel tag.
// Short paths mean the sample was isolated quickly, i.e. anomalous.
module iso_tree_scorer #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 4,
    parameter int NUM_CH     = 4,
    parameter int ANOM_CNT_W = 16,
    localparam int unsigned NODES = 2**DEPTH - 1,
    localparam int CH_W  = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1,
    localparam int PL_W  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [CH_W-1:0]       in_ch,
    input  logic [PL_W-1:0]       score_th,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PL_W-1:0]       out_path,
    output logic                  out_anom,
    output logic [CH_W-1:0]       out_ch,
    input  logic                  cfg_we,
    input  logic [DEPTH-1:0]      cfg_addr,
    input  logic [DATA_W-1:0]     cfg_thr,
    input  logic                  cfg_leaf,
    output logic                  cfg_ack,
    output logic [ANOM_CNT_W-1:0] anom_cnt,
    input  logic                  cnt_clr
);

    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

    state_t            state;
    state_t            state_nxt;

    logic [DATA_W-1:0] node_thr  [NODES];
    logic              node_leaf [NODES];

    logic [DATA_W-1:0] data_q;
    logic [CH_W-1:0]   ch_q;
    logic [PL_W-1:0]   th_q;
    logic [DEPTH-1:0]  idx;
    logic [PL_W-1:0]   level;

    logic              accept;
    logic              cfg_hit;
    logic              cur_leaf;
    logic              go_left;
    logic              last_level;
    logic              walk_end;
    logic              handshake;
    logic [PL_W-1:0]   path_nxt;
    logic [DEPTH-1:0]  idx_nxt;

    // Address NODES (all ones) is not a node and is silently ignored.
    assign accept     = (state == IDLE) && in_valid;
    assign cfg_hit    = (state == IDLE) && cfg_we && (cfg_addr != '1);
    assign cur_leaf   = node_leaf[idx];
    assign go_left    = data_q < node_thr[idx];
    assign last_level = (level == PL_W'(DEPTH - 1));
    assign walk_end   = cur_leaf || last_level;
    assign path_nxt   = cur_leaf ? level : PL_W'(DEPTH);
    // Children of idx are 2*idx+1 / 2*idx+2; top bit of idx is zero whenever a child exists.
    assign idx_nxt    = {idx[DEPTH-2:0], 1'b0} + (go_left ? DEPTH'(1) : DEPTH'(2));
    assign handshake  = out_valid && out_ready;
    assign out_ch     = ch_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept -> walk until leaf or last level -> hold result until consumed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = WALK;
            WALK:    if (walk_end)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Node table; writes only land in IDLE so a walk always sees a stable tree.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NODES; i++) begin
                node_thr[i]  <= '0;
                node_leaf[i] <= 1'b0;
            end
            cfg_ack <= 1'b0;
        end else begin
            cfg_ack <= cfg_hit;
            if (cfg_hit) begin
                node_thr[cfg_addr]  <= cfg_thr;
                node_leaf[cfg_addr] <= cfg_leaf;
            end
        end
    end

    // Sample latch and tree walk; result registers load on the final level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q   <= '0;
            ch_q     <= '0;
            th_q     <= '0;
            idx      <= '0;
            level    <= '0;
            out_path <= '0;
            out_anom <= 1'b0;
        end else if (accept) begin
            data_q <= in_data;
            ch_q   <= in_ch;
            th_q   <= score_th;
            idx    <= '0;
            level  <= '0;
        end else if (state == WALK) begin
            if (walk_end) begin
                out_path <= path_nxt;
                out_anom <= (path_nxt < th_q);
            end else begin
                idx   <= idx_nxt;
                level <= level + PL_W'(1);
            end
        end
    end

    // Saturating count of delivered anomalies; clear has priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            anom_cnt <= '0;
        end else if (cnt_clr) begin
            anom_cnt <= '0;
        end else if (handshake && out_anom && (anom_cnt != '1)) begin
            anom_cnt <= anom_cnt + ANOM_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_iso_tree_scorer.sv
// Scoreboard bench for iso_tree_scorer: stimulus pushes expected results
// computed from a tree-walk model; a monitor pops and compares on output.
module tb_iso_tree_scorer;

    localparam int DATA_W     = 8;
    localparam int DEPTH      = 3;
    localparam int NUM_CH     = 4;
    localparam int ANOM_CNT_W = 2;
    localparam int CH_W       = 2;
    localparam int PL_W       = 2;
    localparam int NODES      = 7;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_data;
    logic [CH_W-1:0]       in_ch;
    logic [PL_W-1:0]       score_th;
    logic                  out_valid;
    logic                  out_ready;
    logic [PL_W-1:0]       out_path;
    logic                  out_anom;
    logic [CH_W-1:0]       out_ch;
    logic                  cfg_we;
    logic [DEPTH-1:0]      cfg_addr;
    logic [DATA_W-1:0]     cfg_thr;
    logic                  cfg_leaf;
    logic                  cfg_ack;
    logic [ANOM_CNT_W-1:0] anom_cnt;
    logic                  cnt_clr;

    logic rand_rdy = 1'b0;
    logic rr = 1'b1;
    logic rdy_force = 1'b1;
    assign out_ready = rand_rdy ? rr : rdy_force;

    iso_tree_scorer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .ANOM_CNT_W(ANOM_CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_ch(in_ch), .score_th(score_th),
        .out_valid(out_valid), .out_ready(out_ready), .out_path(out_path),
        .out_anom(out_anom), .out_ch(out_ch),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_thr(cfg_thr),
        .cfg_leaf(cfg_leaf), .cfg_ack(cfg_ack),
        .anom_cnt(anom_cnt), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int path;
        int anom;
        int ch;
        int acc;
        int lat;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   m_cnt = 0;
    logic [DATA_W-1:0] m_thr [NODES];
    logic              m_leaf [NODES];
    bit   seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1 rr = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference walk: descend from the root until a leaf or the bottom level.
    task automatic model(input logic [DATA_W-1:0] d, output int path, output int lat);
        int idx;
        idx  = 0;
        path = DEPTH;
        lat  = DEPTH;
        for (int lvl = 0; lvl < DEPTH; lvl++) begin
            if (m_leaf[idx]) begin
                path = lvl;
                lat  = lvl + 1;
                break;
            end
            if (lvl == DEPTH - 1) break;
            idx = (d < m_thr[idx]) ? 2 * idx + 1 : 2 * idx + 2;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NODES; i++) begin
            m_thr[i]  = '0;
            m_leaf[i] = 1'b0;
        end
    endtask

    // Monitor: checks counter every cycle and the head of the scoreboard whenever out_valid.
    always @(negedge clk) begin
        bit hs_anom;
        hs_anom = 0;
        if (!reset) begin
            sbq.delete();
            m_cnt = 0;
            seen  = 0;
        end else begin
            chk("anom_cnt", int'(anom_cnt), m_cnt);
            if (out_valid) begin
                chk("in_ready_busy", int'(in_ready), 0);
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: actual out_valid=1 expected no pending sample");
                end else begin
                    if (!seen) chk("latency", cyc - sbq[0].acc, sbq[0].lat);
                    chk("out_path", int'(out_path), sbq[0].path);
                    chk("out_anom", int'(out_anom), sbq[0].anom);
                    chk("out_ch", int'(out_ch), sbq[0].ch);
                    if (out_ready) begin
                        hs_anom = (sbq[0].anom != 0);
                        void'(sbq.pop_front());
                        seen = 0;
                    end else begin
                        seen = 1;
                    end
                end
            end
            if (cnt_clr) m_cnt = 0;
            else if (hs_anom && m_cnt < 3) m_cnt++;
        end
    end

    task automatic send(input logic [DATA_W-1:0] d, input logic [CH_W-1:0] ch,
                        input logic [PL_W-1:0] th, input bit do_cfg,
                        input logic [DEPTH-1:0] a, input logic [DATA_W-1:0] t,
                        input logic lf);
        int p, l;
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d; in_ch = ch; score_th = th;
        if (do_cfg) begin
            cfg_we = 1'b1; cfg_addr = a; cfg_thr = t; cfg_leaf = lf;
        end
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: actual in_ready=0 expected 1 within 200 cycles");
        end else begin
            if (do_cfg && a != 3'd7) begin
                m_thr[a]  = t;
                m_leaf[a] = lf;
            end
            model(d, p, l);
            sbq.push_back('{path: p, anom: (p < int'(th)) ? 1 : 0, ch: int'(ch),
                            acc: cyc + 1, lat: l});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        if (do_cfg && ok) begin
            @(negedge clk);
            chk("cfg_ack_with_accept", int'(cfg_ack), (a != 3'd7) ? 1 : 0);
        end
    endtask

    task automatic sample(input logic [DATA_W-1:0] d, input logic [CH_W-1:0] ch,
                          input logic [PL_W-1:0] th);
        send(d, ch, th, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic cfg_write(input logic [DEPTH-1:0] a, input logic [DATA_W-1:0] t,
                             input logic lf, input int exp_ack);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = a; cfg_thr = t; cfg_leaf = lf;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        @(negedge clk);
        chk("cfg_ack", int'(cfg_ack), exp_ack);
        if (exp_ack != 0) begin
            m_thr[a]  = t;
            m_leaf[a] = lf;
        end
        @(negedge clk);
        chk("cfg_ack_pulse", int'(cfg_ack), 0);
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (sbq.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: actual pending=%0d expected 0", sbq.size());
        end
    endtask

    task automatic wait_out_valid();
        bit ok;
        ok = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL out_valid_timeout: actual out_valid=0 expected 1");
        end
    endtask

    task automatic check_reset_state();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_path", int'(out_path), 0);
        chk("rst_out_anom", int'(out_anom), 0);
        chk("rst_out_ch", int'(out_ch), 0);
        chk("rst_cfg_ack", int'(cfg_ack), 0);
        chk("rst_anom_cnt", int'(anom_cnt), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_valid = 1'b0; in_data = '0; in_ch = '0; score_th = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_thr = '0; cfg_leaf = 1'b0;
        cnt_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_reset_state();

        // Test tree.
        cfg_write(3'd0, 8'h80, 1'b0, 1);
        cfg_write(3'd1, 8'h00, 1'b1, 1);
        cfg_write(3'd2, 8'hC0, 1'b0, 1);
        cfg_write(3'd5, 8'h00, 1'b0, 1);

        // Leaf hit at level 1, then a full-depth walk.
        sample(8'h10, 2'd2, 2'd2);
        drain();
        sample(8'hAB, 2'd1, 2'd2);
        drain();

        // Back-pressure: result held while out_ready is low.
        rdy_force = 1'b0;
        sample(8'h10, 2'd3, 2'd2);
        wait_out_valid();
        repeat (5) @(negedge clk);
        @(posedge clk); #1 rdy_force = 1'b1;
        drain();

        // Writes during a walk are dropped; same-cycle IDLE write is seen by the walk.
        sample(8'h10, 2'd0, 2'd2);
        cfg_write(3'd1, 8'h00, 1'b0, 0);
        drain();
        sample(8'h10, 2'd3, 2'd2);
        drain();
        send(8'h10, 2'd2, 2'd3, 1'b1, 3'd1, 8'h00, 1'b0);
        drain();
        cfg_write(3'd7, 8'h55, 1'b1, 0);
        send(8'h10, 2'd1, 2'd2, 1'b1, 3'd1, 8'h00, 1'b1);
        drain();

        // Threshold boundaries.
        sample(8'h10, 2'd0, 2'd0);
        drain();
        sample(8'hAB, 2'd2, 2'd3);
        drain();

        // Saturation then clear racing an anomalous handshake.
        for (int i = 0; i < 5; i++) begin
            sample(8'h10, 2'(i), 2'd3);
            drain();
        end
        @(negedge clk);
        chk("cnt_saturated", int'(anom_cnt), 3);
        rdy_force = 1'b0;
        sample(8'h10, 2'd1, 2'd3);
        wait_out_valid();
        @(posedge clk); #1;
        cnt_clr = 1'b1; rdy_force = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("cnt_cleared", int'(anom_cnt), 0);
        drain();

        // Randomized traffic with random back-pressure and tree rewrites.
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                logic [DEPTH-1:0] a;
                a = 3'($urandom_range(0, 7));
                drain();
                cfg_write(a, 8'($urandom), 1'($urandom_range(0, 1)), (a != 3'd7) ? 1 : 0);
            end
            sample(8'($urandom), 2'($urandom), 2'($urandom));
        end
        drain();
        rand_rdy = 1'b0;
        rdy_force = 1'b1;

        // Reset during a walk aborts the sample and clears the tree.
        cfg_write(3'd0, 8'hFF, 1'b0, 1);
        sample(8'h10, 2'd2, 2'd1);
        #1 reset = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_mid_walk_out_valid", int'(out_valid), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_reset_state();
        repeat (4) @(negedge clk);
        chk("no_output_after_abort", int'(out_valid), 0);
        sample(8'h10, 2'd1, 2'd3);
        drain();
        sample(8'h00, 2'd3, 2'd0);
        drain();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
